sound_mem_arbiter: RTL and testbench

Shares the single sound-RAM memory port between two clients: GLU CPU-side writes, which are fire-and-forget pulses with no back-pressure, and DOC5503 wave-fetch reads, which are one outstanding read that waits for ready and data. GLU writes are buffered in a small FIFO. DOC reads have priority, with a starvation guard for writes. The block sits between the GLU/DOC logic and the SDRAM controller port.

---
 rtl/sound_mem_arbiter_if.sv | 36 +++
 rtl/sound_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sound_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_mem_arbiter_if.sv
// Signal bundle between the GLU/DOC clients, the sound-RAM arbiter and the SDRAM controller port.
// The master modport is the surrounding logic; the slave modport is the arbiter itself.
interface sound_mem_arbiter_if;
  logic        glu_wr_i;
  logic [20:0] glu_addr_i;
  logic [31:0] glu_data_i;
  logic [3:0]  glu_byte_en_i;
  logic        doc_rd_i;
  logic [20:0] doc_addr_i;
  logic        doc_ready_o;
  logic [31:0] doc_q_o;
  logic        mem_rd_o;
  logic        mem_wr_o;
  logic [20:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_byte_en_o;
  logic        mem_ready_i;
  logic [31:0] mem_q_i;
  logic        wr_overflow_o;
  logic        rd_overrun_o;
  logic        busy_o;

  modport master (
    output glu_wr_i, glu_addr_i, glu_data_i, glu_byte_en_i, doc_rd_i, doc_addr_i,
           mem_ready_i, mem_q_i,
    input  doc_ready_o, doc_q_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o,
           mem_byte_en_o, wr_overflow_o, rd_overrun_o, busy_o
  );

  modport slave (
    input  glu_wr_i, glu_addr_i, glu_data_i, glu_byte_en_i, doc_rd_i, doc_addr_i,
           mem_ready_i, mem_q_i,
    output doc_ready_o, doc_q_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o,
           mem_byte_en_o, wr_overflow_o, rd_overrun_o, busy_o
  );
endinterface

// File: rtl/sound_mem_arbiter.sv
// Shares one sound-RAM port between buffered GLU writes and single-outstanding DOC reads.
// Reads win arbitration unless MAX_RD_STREAK reads in a row have passed while writes wait.
module sound_mem_arbiter #(
  parameter int WR_FIFO_DEPTH = 4,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic               clk_logic,
  input  logic               system_reset_n,
  sound_mem_arbiter_if.slave bus
);
  localparam int AW = $clog2(WR_FIFO_DEPTH);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);
  localparam int EW = 21 + 32 + 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_BUSY = 2'd1,
    ST_WR_BUSY = 2'd2
  } state_t;

  state_t        r_state;
  logic [EW-1:0] r_fifo_mem [WR_FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_slot_valid;
  logic [20:0]   r_slot_addr;
  logic [SW-1:0] r_streak;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic [20:0]   r_mem_addr;
  logic [31:0]   r_mem_data;
  logic [3:0]    r_mem_be;
  logic          r_doc_ready;
  logic [31:0]   r_doc_q;
  logic          r_wr_overflow;
  logic          r_rd_overrun;
  logic          r_busy;

  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [EW-1:0] w_fifo_head;
  logic          w_rd_grant;
  logic          w_wr_grant;
  logic          w_push;
  logic          w_done;
  logic          w_rd_done;
  logic          w_rd_inflight;

  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_fifo_head  = r_fifo_mem[r_rd_ptr[AW-1:0]];
  assign w_rd_grant   = (r_state == ST_IDLE) && r_slot_valid &&
                        (w_fifo_empty || (r_streak < SW'(MAX_RD_STREAK)));
  assign w_wr_grant   = (r_state == ST_IDLE) && !w_rd_grant && !w_fifo_empty;
  assign w_push       = bus.glu_wr_i && (!w_fifo_full || w_wr_grant);
  // A ready coinciding with the issue pulse belongs to nobody and is not taken.
  assign w_done       = bus.mem_ready_i && !r_mem_rd && !r_mem_wr;
  assign w_rd_done    = (r_state == ST_RD_BUSY) && w_done;
  assign w_rd_inflight = ((r_state == ST_RD_BUSY) && !w_done) || w_rd_grant;

  assign bus.doc_ready_o   = r_doc_ready;
  assign bus.doc_q_o       = r_doc_q;
  assign bus.mem_rd_o      = r_mem_rd;
  assign bus.mem_wr_o      = r_mem_wr;
  assign bus.mem_addr_o    = r_mem_addr;
  assign bus.mem_data_o    = r_mem_data;
  assign bus.mem_byte_en_o = r_mem_be;
  assign bus.wr_overflow_o = r_wr_overflow;
  assign bus.rd_overrun_o  = r_rd_overrun;
  assign bus.busy_o        = r_busy;

  // Arbiter FSM with write FIFO, read slot, streak counter and all registered outputs.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_slot_valid  <= 1'b0;
      r_slot_addr   <= 21'd0;
      r_streak      <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= 21'd0;
      r_mem_data    <= 32'd0;
      r_mem_be      <= 4'b1111;
      r_doc_ready   <= 1'b0;
      r_doc_q       <= 32'd0;
      r_wr_overflow <= 1'b0;
      r_rd_overrun  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_doc_ready <= 1'b0;

      if (w_push) begin
        r_fifo_mem[r_wr_ptr[AW-1:0]] <= {bus.glu_addr_i, bus.glu_data_i, bus.glu_byte_en_i};
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end else if (bus.glu_wr_i) begin
        r_wr_overflow <= 1'b1;
      end else begin
        r_wr_overflow <= r_wr_overflow;
      end

      // A request landing on the completion cycle refills the slot the completion frees.
      if (bus.doc_rd_i && w_rd_inflight) begin
        r_rd_overrun <= 1'b1;
      end else if (bus.doc_rd_i) begin
        r_slot_valid <= 1'b1;
        r_slot_addr  <= bus.doc_addr_i;
      end else if (w_rd_done) begin
        r_slot_valid <= 1'b0;
      end else begin
        r_slot_valid <= r_slot_valid;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_rd_grant) begin
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_slot_addr;
            r_mem_data <= 32'd0;
            r_mem_be   <= 4'b1111;
            r_state    <= ST_RD_BUSY;
            r_busy     <= 1'b1;
            r_streak   <= w_fifo_empty ? '0 : (r_streak + SW'(1));
          end else if (w_wr_grant) begin
            r_mem_wr   <= 1'b1;
            {r_mem_addr, r_mem_data, r_mem_be} <= w_fifo_head;
            r_rd_ptr   <= r_rd_ptr + (AW+1)'(1);
            r_state    <= ST_WR_BUSY;
            r_busy     <= 1'b1;
            r_streak   <= '0;
          end else begin
            r_streak   <= '0;
          end
        end
        ST_RD_BUSY: begin
          if (w_done) begin
            r_doc_q     <= bus.mem_q_i;
            r_doc_ready <= 1'b1;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
          end else begin
            r_state     <= ST_RD_BUSY;
          end
        end
        ST_WR_BUSY: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_WR_BUSY;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sound_mem_arbiter.sv
// Scoreboard bench for sound_mem_arbiter: expected memory ops and DOC read data are queued
// when stimulus is driven and popped when the arbiter issues to memory or returns DOC data.
module tb_sound_mem_arbiter;
  typedef struct packed {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } op_t;

  logic clk;
  logic rst_n;

  sound_mem_arbiter_if bus ();

  sound_mem_arbiter #(
    .WR_FIFO_DEPTH(4),
    .MAX_RD_STREAK(4)
  ) dut (
    .clk_logic     (clk),
    .system_reset_n(rst_n),
    .bus           (bus)
  );

  int          n_checks     = 0;
  int          n_pass       = 0;
  op_t         exp_ops[$];
  logic [31:0] exp_q[$];
  int          latency      = 3;
  int          resp_cnt     = 0;
  logic        resp_is_rd   = 1'b0;
  logic [20:0] resp_addr    = 21'd0;
  logic [20:0] held_addr    = 21'd0;
  logic        ready_was_rd = 1'b0;
  int          auto_rd_left = 0;
  logic [20:0] auto_addr    = 21'd0;
  logic        auto_drove   = 1'b0;
  string       seq          = "";

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [20:0] a);
    if (a == 21'h10005) return 32'hA1B2C3D4;
    else return {a[15:0], ~a[15:0]};
  endfunction

  function automatic op_t mk_op(input logic wr, input logic [20:0] a, input logic [31:0] d,
                                input logic [3:0] be);
    op_t o;
    o.wr = wr; o.addr = a; o.data = d; o.be = be;
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic drive_cycle(input logic wr, input logic [20:0] wa, input logic [31:0] wd,
                             input logic [3:0] wbe, input logic rd, input logic [20:0] ra);
    bus.glu_wr_i = wr; bus.glu_addr_i = wa; bus.glu_data_i = wd; bus.glu_byte_en_i = wbe;
    bus.doc_rd_i = rd; bus.doc_addr_i = ra;
    @(negedge clk);
    bus.glu_wr_i = 1'b0;
    bus.doc_rd_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((exp_ops.size() != 0 || exp_q.size() != 0 || resp_cnt != 0 || bus.busy_o !== 1'b0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(n < budget), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Memory responder and scoreboard monitor; samples on the falling edge.
  initial begin : mem_model
    op_t got;
    forever begin
      @(negedge clk);
      if (bus.doc_ready_o === 1'b1 || ready_was_rd) begin
        check_eq("doc_ready_timing", 64'(bus.doc_ready_o), 64'(ready_was_rd));
        if (bus.doc_ready_o === 1'b1) begin
          if (exp_q.size() == 0) check_eq("doc_ready_unexpected", 64'(bus.doc_q_o), 64'hFFFF_FFFF_FFFF_FFFF);
          else check_eq("doc_q", 64'(bus.doc_q_o), 64'(exp_q.pop_front()));
        end
      end
      ready_was_rd    = 1'b0;
      bus.mem_ready_i = 1'b0;
      if (auto_drove) begin
        bus.doc_rd_i = 1'b0;
        auto_drove   = 1'b0;
      end
      if (bus.mem_rd_o === 1'b1 || bus.mem_wr_o === 1'b1) begin
        got = mk_op(bus.mem_wr_o, bus.mem_addr_o, bus.mem_wr_o ? bus.mem_data_o : 32'h0,
                    bus.mem_byte_en_o);
        if (bus.mem_wr_o) seq = {seq, "W"};
        else seq = {seq, "R"};
        check_eq("single_issue", 64'(bus.mem_rd_o & bus.mem_wr_o), 64'd0);
        check_eq("issue_while_busy", 64'(resp_cnt), 64'd0);
        if (exp_ops.size() == 0) check_eq("unexpected_issue", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
        else check_eq("mem_op", 64'(got), 64'(exp_ops.pop_front()));
        resp_cnt   = latency;
        resp_is_rd = bus.mem_rd_o;
        resp_addr  = bus.mem_addr_o;
        held_addr  = bus.mem_addr_o;
      end else if (resp_cnt > 0) begin
        if (bus.busy_o === 1'b1) check_eq("addr_hold", 64'(bus.mem_addr_o), 64'(held_addr));
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.mem_ready_i = 1'b1;
          bus.mem_q_i     = resp_is_rd ? mem_word(resp_addr) : 32'hDEAD_BEEF;
          ready_was_rd    = resp_is_rd;
          if (resp_is_rd && auto_rd_left > 0) begin
            auto_rd_left--;
            auto_addr      = auto_addr + 21'd1;
            bus.doc_addr_i = auto_addr;
            bus.doc_rd_i   = 1'b1;
            auto_drove     = 1'b1;
            exp_q.push_back(mem_word(auto_addr));
          end
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] be_tab [5];
    int n;
    be_tab[0] = 4'b0001; be_tab[1] = 4'b0100; be_tab[2] = 4'b0010;
    be_tab[3] = 4'b1000; be_tab[4] = 4'b1111;
    bus.glu_wr_i = 1'b0; bus.glu_addr_i = 21'd0; bus.glu_data_i = 32'd0; bus.glu_byte_en_i = 4'd0;
    bus.doc_rd_i = 1'b0; bus.doc_addr_i = 21'd0; bus.mem_ready_i = 1'b0; bus.mem_q_i = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_flags", 64'({bus.doc_ready_o, bus.mem_rd_o, bus.mem_wr_o, bus.wr_overflow_o,
                              bus.rd_overrun_o, bus.busy_o}), 64'd0);
    check_eq("rst_byte_en", 64'(bus.mem_byte_en_o), 64'hF);
    check_eq("rst_doc_q", 64'(bus.doc_q_o), 64'd0);
    check_eq("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single DOC read, memory answers three cycles after the issue pulse.
    latency = 3; seq = "";
    exp_ops.push_back(mk_op(1'b0, 21'h10005, 32'h0, 4'b1111));
    exp_q.push_back(32'hA1B2C3D4);
    drive_cycle(1'b0, 21'd0, 32'd0, 4'd0, 1'b1, 21'h10005);
    wait_idle("t1_drain", 60);
    check_eq("t1_one_read", 64'(seq == "R"), 64'd1);

    // Five back-to-back GLU writes into a stalled memory, then one more into a full FIFO.
    latency = 12; seq = "";
    for (int i = 0; i < 5; i++)
      exp_ops.push_back(mk_op(1'b1, 21'h00200 + 21'(i), 32'hC0DE_0000 | 32'(i), be_tab[i]));
    for (int i = 0; i < 5; i++)
      drive_cycle(1'b1, 21'h00200 + 21'(i), 32'hC0DE_0000 | 32'(i), be_tab[i], 1'b0, 21'd0);
    check_eq("t2_no_overflow", 64'(bus.wr_overflow_o), 64'd0);
    drive_cycle(1'b1, 21'h00299, 32'hBAD0_0000, 4'b1111, 1'b0, 21'd0);
    check_eq("t2_overflow", 64'(bus.wr_overflow_o), 64'd1);
    wait_idle("t2_drain", 300);
    check_eq("t2_order", 64'(seq == "WWWWW"), 64'd1);

    // Read and write in the same cycle: the read goes first.
    latency = 3; seq = "";
    exp_ops.push_back(mk_op(1'b0, 21'h00300, 32'h0, 4'b1111));
    exp_ops.push_back(mk_op(1'b1, 21'h00301, 32'h3333_0301, 4'b1010));
    exp_q.push_back(mem_word(21'h00300));
    drive_cycle(1'b1, 21'h00301, 32'h3333_0301, 4'b1010, 1'b1, 21'h00300);
    wait_idle("t3_drain", 60);
    check_eq("t3_read_first", 64'(seq == "RW"), 64'd1);

    // Continuous DOC reads with two writes queued: a write is forced every fifth slot.
    latency = 2; seq = "";
    for (int i = 0; i < 4; i++) exp_ops.push_back(mk_op(1'b0, 21'h00400 + 21'(i), 32'h0, 4'b1111));
    exp_ops.push_back(mk_op(1'b1, 21'h00500, 32'h5000_0000, 4'b0011));
    for (int i = 4; i < 8; i++) exp_ops.push_back(mk_op(1'b0, 21'h00400 + 21'(i), 32'h0, 4'b1111));
    exp_ops.push_back(mk_op(1'b1, 21'h00501, 32'h5000_0001, 4'b1100));
    exp_q.push_back(mem_word(21'h00400));
    auto_addr = 21'h00400; auto_rd_left = 7;
    drive_cycle(1'b1, 21'h00500, 32'h5000_0000, 4'b0011, 1'b1, 21'h00400);
    drive_cycle(1'b1, 21'h00501, 32'h5000_0001, 4'b1100, 1'b0, 21'd0);
    wait_idle("t4_drain", 200);
    check_eq("t4_sequence", 64'(seq == "RRRRWRRRRW"), 64'd1);

    // Two DOC requests before issue (latest wins), then one while the read is in flight.
    latency = 8; seq = "";
    exp_ops.push_back(mk_op(1'b1, 21'h00600, 32'h6666_0600, 4'b1111));
    exp_ops.push_back(mk_op(1'b0, 21'h00200, 32'h0, 4'b1111));
    exp_q.push_back(mem_word(21'h00200));
    drive_cycle(1'b1, 21'h00600, 32'h6666_0600, 4'b1111, 1'b0, 21'd0);
    repeat (2) @(negedge clk);
    drive_cycle(1'b0, 21'd0, 32'd0, 4'd0, 1'b1, 21'h00100);
    drive_cycle(1'b0, 21'd0, 32'd0, 4'd0, 1'b1, 21'h00200);
    check_eq("t5_no_overrun", 64'(bus.rd_overrun_o), 64'd0);
    n = 0;
    while (bus.mem_rd_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_rd_issued", 64'(n < 40), 64'd1);
    drive_cycle(1'b0, 21'd0, 32'd0, 4'd0, 1'b1, 21'h00700);
    check_eq("t5_overrun", 64'(bus.rd_overrun_o), 64'd1);
    wait_idle("t5_drain", 100);
    check_eq("t5_sequence", 64'(seq == "WR"), 64'd1);

    // Reset during WR_BUSY with a buffered write behind it and a stale ready afterwards.
    latency = 4; seq = "";
    exp_ops.push_back(mk_op(1'b1, 21'h00800, 32'h8888_0800, 4'b0110));
    drive_cycle(1'b1, 21'h00800, 32'h8888_0800, 4'b0110, 1'b0, 21'd0);
    drive_cycle(1'b1, 21'h00801, 32'h8888_0801, 4'b1001, 1'b0, 21'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t6_idle", 64'(bus.busy_o), 64'd0);
    check_eq("t6_flags", 64'({bus.wr_overflow_o, bus.rd_overrun_o}), 64'd0);
    check_eq("t6_byte_en", 64'(bus.mem_byte_en_o), 64'hF);
    check_eq("t6_no_new_issue", 64'(seq == "W"), 64'd1);

    check_eq("end_ops_left", 64'(exp_ops.size()), 64'd0);
    check_eq("end_q_left", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
